// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, blank
// pattern and the index-width helper.
package seg7_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b0000000;

   // Active-high glyphs, bit6 = a ... bit0 = g; entry 0 is rightmost.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'b1000111,  // F
      7'b1001111,  // E
      7'b0111101,  // d
      7'b1001110,  // C
      7'b0011111,  // b
      7'b1110111,  // A
      7'b1111011,  // 9
      7'b1111111,  // 8
      7'b1110000,  // 7
      7'b1011111,  // 6
      7'b1011011,  // 5
      7'b0110011,  // 4
      7'b1111001,  // 3
      7'b1101101,  // 2
      7'b0110000,  // 1
      7'b1111110   // 0
   };

   // Ceiling log2 with a floor of 1 so a single-digit bank still has a port.
   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   assign segs = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with shadowed data, per-digit
// enables/dp, leading-zero blanking and selectable output polarity.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1,
   localparam int IDX_W      = clog2(NUM_DIGITS)
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    blank_lz,
   input  logic                    load,
   output logic [6:0]              a_to_g,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        scan_idx
);

   localparam int              PRE_W    = clog2(REFRESH_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic            INV      = ACTIVE_LOW;

   logic [PRE_W-1:0]        pre_q;
   logic [IDX_W-1:0]        idx_q;
   logic [4*NUM_DIGITS-1:0] value_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [NUM_DIGITS-1:0]   dark_q;

   logic [NUM_DIGITS-1:0]   zero_run;
   logic [NUM_DIGITS-1:0]   an_hot;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_dark;
   logic                    cur_zero;
   logic                    blank;
   logic [6:0]              glyph_segs;
   logic [6:0]              seg_next;
   logic                    dp_next;

   // Prescaler and digit index; load never disturbs the scan phase.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         pre_q <= '0;
         idx_q <= '0;
      end else if (pre_q == PRE_LAST) begin
         pre_q <= '0;
         idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   // Enables are kept as a dark mask so the all-zero cleared state lights
   // every digit and an empty word reads as "0".
   // NOTE: shadow registers are cleared explicitly; they are flops, not a RAM.
   always_ff @(posedge clk) begin
      if (clr) begin
         value_q <= '0;
         dp_q    <= '0;
         dark_q  <= '0;
      end else if (load) begin
         value_q <= value;
         dp_q    <= dp_in;
         dark_q  <= ~digit_en;
      end
   end

   // zero_run[i]: nibbles i..NUM_DIGITS-1 are all zero.
   always_comb begin
      logic run;
      // NOTE: every combinational output gets a default first so no latch forms.
      zero_run = '0;
      run      = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run         = run & (value_q[4*i +: 4] == 4'h0);
         zero_run[i] = run;
      end
   end

   always_comb begin
      cur_nib  = '0;
      cur_dp   = 1'b0;
      cur_dark = 1'b0;
      cur_zero = 1'b0;
      an_hot   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib   = value_q[4*i +: 4];
            cur_dp    = dp_q[i];
            cur_dark  = dark_q[i];
            cur_zero  = zero_run[i] && (i != 0);
            an_hot[i] = 1'b1;
         end
      end
   end

   seg7_glyph u_glyph (
      .nibble (cur_nib),
      .segs   (glyph_segs)
   );

   always_comb begin
      blank    = cur_dark | (blank_lz & cur_zero);
      seg_next = blank ? SEG_BLANK : glyph_segs;
      dp_next  = ~blank & cur_dp;
   end

   // Anode and segments share one edge, so digits never overlap on a switch.
   always_ff @(posedge clk) begin
      if (clr) begin
         a_to_g   <= {7{INV}};
         dp       <= INV;
         an       <= {NUM_DIGITS{INV}};
         scan_idx <= '0;
      end else begin
         a_to_g   <= seg_next ^ {7{INV}};
         dp       <= dp_next ^ INV;
         an       <= an_hot ^ {NUM_DIGITS{INV}};
         scan_idx <= idx_q;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver against a frame-arithmetic model,
// covering both polarities and an 8-digit/3-cycle configuration.
module tb_seg7_scan_driver;

   typedef struct packed {
      logic [15:0] an;
      logic [6:0]  seg;
      logic        dp;
      logic [3:0]  idx;
   } obs_t;

   typedef struct packed {
      logic [63:0] val;
      logic [15:0] dpm;
      logic [15:0] enm;
      logic [31:0] cnt;
   } sh_t;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Stream A: 4 digits, 4 cycles per digit, both polarities.
   logic        clr_a = 1'b1, load_a = 1'b0, blz_a = 1'b0;
   logic [15:0] value_a = '0;
   logic [3:0]  dp_a = '0, en_a = '0;
   logic [6:0]  seg_l, seg_h;
   logic        dp_l, dp_h;
   logic [3:0]  an_l, an_h;
   logic [1:0]  idx_l, idx_h;

   // Stream B: 8 digits, 3 cycles per digit, active-low.
   logic        clr_b = 1'b1, load_b = 1'b0, blz_b = 1'b0;
   logic [31:0] value_b = '0;
   logic [7:0]  dp_b = '0, en_b = '0;
   logic [6:0]  seg_b;
   logic        dp_bo;
   logic [7:0]  an_b;
   logic [2:0]  idx_b;

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .clr(clr_a), .value(value_a), .dp_in(dp_a), .digit_en(en_a),
      .blank_lz(blz_a), .load(load_a), .a_to_g(seg_l), .dp(dp_l), .an(an_l),
      .scan_idx(idx_l));

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .clr(clr_a), .value(value_a), .dp_in(dp_a), .digit_en(en_a),
      .blank_lz(blz_a), .load(load_a), .a_to_g(seg_h), .dp(dp_h), .an(an_h),
      .scan_idx(idx_h));

   seg7_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(3), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .clr(clr_b), .value(value_b), .dp_in(dp_b), .digit_en(en_b),
      .blank_lz(blz_b), .load(load_b), .a_to_g(seg_b), .dp(dp_bo), .an(an_b),
      .scan_idx(idx_b));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;  default: return 7'b1000111;
      endcase
   endfunction

   // Active-high view of what is on the bank after `cnt` running cycles.
   function automatic obs_t predict(input int nd, input int rd, input sh_t s, input logic blz);
      obs_t        o;
      int          d;
      logic [63:0] upper;
      logic        blank;
      d      = int'(s.cnt % 32'(nd * rd)) / rd;
      upper  = s.val >> (4 * d);
      blank  = !s.enm[d] || (blz && d != 0 && upper == 64'd0);
      o.an   = 16'd1 << d;
      o.idx  = 4'(d);
      o.seg  = blank ? 7'b0 : glyph(upper[3:0]);
      o.dp   = !blank && s.dpm[d];
      return o;
   endfunction

   sh_t  sh_a, sh_b;
   obs_t exp_a, exp_b;
   logic ok_a = 1'b0, ok_b = 1'b0, rst_b = 1'b1;

   always @(posedge clk) begin
      if (clr_a) begin
         exp_a = '0;
         sh_a  = '0;
         sh_a.enm = 16'hFFFF;
      end else begin
         exp_a = predict(4, 4, sh_a, blz_a);
         sh_a.cnt = sh_a.cnt + 1;
         if (load_a) begin
            sh_a.val = 64'(value_a);
            sh_a.dpm = 16'(dp_a);
            sh_a.enm = 16'(en_a);
         end
      end
      ok_a = 1'b1;
   end

   always @(posedge clk) begin
      rst_b = clr_b;
      if (clr_b) begin
         exp_b = '0;
         sh_b  = '0;
         sh_b.enm = 16'hFFFF;
      end else begin
         exp_b = predict(8, 3, sh_b, blz_b);
         sh_b.cnt = sh_b.cnt + 1;
         if (load_b) begin
            sh_b.val = 64'(value_b);
            sh_b.dpm = 16'(dp_b);
            sh_b.enm = 16'(en_b);
         end
      end
      ok_b = 1'b1;
   end

   always @(negedge clk) begin : cmp
      logic [3:0] ea_lo;
      logic [6:0] es_lo;
      logic       ed_lo;
      logic [7:0] eb_an;
      logic [6:0] eb_seg;
      logic       eb_dp;
      if (ok_a) begin
         ea_lo = ~exp_a.an[3:0];
         es_lo = ~exp_a.seg;
         ed_lo = ~exp_a.dp;
         check("a_an_lo",  an_l,  ea_lo);
         check("a_seg_lo", seg_l, es_lo);
         check("a_dp_lo",  dp_l,  ed_lo);
         check("a_idx_lo", idx_l, exp_a.idx[1:0]);
         check("a_an_hi",  an_h,  exp_a.an[3:0]);
         check("a_seg_hi", seg_h, exp_a.seg);
         check("a_dp_hi",  dp_h,  exp_a.dp);
         check("a_idx_hi", idx_h, exp_a.idx[1:0]);
      end
      if (ok_b) begin
         eb_an  = ~exp_b.an[7:0];
         eb_seg = ~exp_b.seg;
         eb_dp  = ~exp_b.dp;
         check("b_an",  an_b,  eb_an);
         check("b_seg", seg_b, eb_seg);
         check("b_dp",  dp_bo, eb_dp);
         check("b_idx", idx_b, exp_b.idx[2:0]);
         if (!rst_b) begin
            check("b_onehot", 32'($countones(~an_b)), 32'd1);
            check("b_idx_an", an_b[idx_b], 1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a_word(input logic [15:0] v, input logic [3:0] en,
                              input logic [3:0] dpv, input logic blz);
      value_a = v; en_a = en; dp_a = dpv; blz_a = blz; load_a = 1'b1;
      tick();
      load_a = 1'b0;
      tick();
   endtask

   task automatic run_a();
      repeat (3) tick();
      check("rst_an_lo",  an_l,  4'b1111);
      check("rst_seg_lo", seg_l, 7'b1111111);
      check("rst_dp_lo",  dp_l,  1'b1);
      check("rst_an_hi",  an_h,  4'b0000);
      check("rst_seg_hi", seg_h, 7'b0000000);
      clr_a = 1'b0;
      tick();
      check("rel_an_lo",  an_l,  4'b1110);
      check("rel_seg_lo", seg_l, 7'b0000001);
      check("rel_an_hi",  an_h,  4'b0001);
      check("rel_seg_hi", seg_h, 7'b1111110);

      load_a_word(16'h1A3F, 4'b1111, 4'b0100, 1'b0);
      for (int t = 0; t < 16; t++) begin
         case (an_l)
            4'b1110: begin check("scan_F", seg_l, 7'b0111000); check("scan_dp0", dp_l, 1'b1); end
            4'b1101: check("scan_3", seg_l, 7'b0000110);
            4'b1011: begin check("scan_A", seg_l, 7'b0001000); check("scan_dp2", dp_l, 1'b0); end
            4'b0111: check("scan_1", seg_l, 7'b1001111);
            default: check("scan_an_valid", an_l, 4'b1110);
         endcase
         tick();
      end

      load_a_word(16'h0050, 4'b1111, 4'b0000, 1'b1);
      for (int t = 0; t < 16; t++) begin
         case (an_l)
            4'b1110: check("lz_d0", seg_l, 7'b0000001);
            4'b1101: check("lz_d1", seg_l, 7'b0100100);
            default: check("lz_blank", seg_l, 7'b1111111);
         endcase
         tick();
      end
      load_a_word(16'h0000, 4'b1111, 4'b0000, 1'b1);
      for (int t = 0; t < 16; t++) begin
         check("lz0_seg", seg_l, (an_l == 4'b1110) ? 7'b0000001 : 7'b1111111);
         tick();
      end

      load_a_word(16'h0000, 4'b1111, 4'b0000, 1'b0);
      value_a = 16'hFFFF; load_a = 1'b1;
      tick();
      load_a = 1'b0;
      check("ld_before", seg_l, 7'b0000001);
      tick();
      check("ld_after", seg_l, 7'b0111000);
      clr_a = 1'b1; load_a = 1'b1;
      tick();
      check("clrld_an", an_l, 4'b1111);
      clr_a = 1'b0; load_a = 1'b0;
      tick();
      check("clrld_an0",  an_l,  4'b1110);
      check("clrld_seg0", seg_l, 7'b0000001);

      load_a_word(16'h1234, 4'b0101, 4'b0000, 1'b0);
      for (int t = 0; t < 16; t++) begin
         case (an_l)
            4'b1110: check("en_d0", seg_l, 7'b1001100);
            4'b1011: check("en_d2", seg_l, 7'b0010010);
            default: check("en_dark", seg_l, 7'b1111111);
         endcase
         tick();
      end

      for (int t = 0; t < 600; t++) begin
         clr_a  = ($urandom_range(0, 63) == 0);
         load_a = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < 4; k++)
            value_a[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
         dp_a  = 4'($urandom);
         en_a  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
         blz_a = 1'($urandom_range(0, 1));
         tick();
      end
      clr_a = 1'b0; load_a = 1'b0;
      tick();
   endtask

   task automatic run_b();
      repeat (2) tick();
      clr_b = 1'b0;
      for (int t = 0; t < 26; t++) begin
         tick();
         if (t == 0 || t == 2 || t == 24) check("frame_d0", an_b, 8'hFE);
         if (t == 3) begin check("frame_d1", an_b, 8'hFD); check("frame_idx1", idx_b, 3'd1); end
         if (t == 23) check("frame_d7", an_b, 8'h7F);
      end
      for (int t = 0; t < 300; t++) begin
         clr_b   = ($urandom_range(0, 99) == 0);
         load_b  = ($urandom_range(0, 4) == 0);
         for (int k = 0; k < 8; k++)
            value_b[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
         dp_b  = 8'($urandom);
         en_b  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
         blz_b = 1'($urandom_range(0, 1));
         tick();
      end
      clr_b = 1'b0; load_b = 1'b0;
      tick();
   endtask

   initial begin
      fork
         run_a();
         run_b();
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed N-digit seven-segment display driver for the RSA demo top level. It shows a packed hex word (ciphertext, key or plaintext nibbles) on the board's common-anode digit bank. The block latches the word on a load strobe and scans one digit at a time at a parametrised refresh rate. It also drives per-digit decimal points, per-digit enables and optional leading-zero blanking. Segment and anode polarity are selectable.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16)
- REFRESH_DIV, 100000, clock cycles each digit is held (≥2)
- ACTIVE_LOW, 1, 1 = segments/dp/anodes driven low-true; 0 = high-true

Ports:
- clk  in  1  system clock; all state on rising edge
- clr  in  1  synchronous active-high reset
- value  in  4*NUM_DIGITS  hex word; digit i = value[4i+3:4i], digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit)
- digit_en  in  NUM_DIGITS  per-digit enable (0 = digit dark)
- blank_lz  in  1  1 = suppress leading zeros
- load  in  1  single-cycle strobe: capture value/dp_in/digit_en into shadow regs
- a_to_g  out  7  segments, bit6 = a … bit0 = g
- dp  out  1  decimal point
- an  out  NUM_DIGITS  digit anodes, one-hot active
- scan_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently driven

## Operation
- Shadow registers hold value, dp and enables. They update only on a clk edge with load=1; inputs are ignored otherwise. Display picks up new data one cycle after the load edge. The scan counter is unaffected by load.
- Prescaler counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and idx advances. idx wraps NUM_DIGITS-1 → 0.
- Glyphs, active-high (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Digit i is blank (all segments and dp off, anode still active) when either:
  - shadow enable[i]=0, or
  - blank_lz=1, i≠0, and shadow nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never zero-blanked, so an all-zero word shows a single "0".
- dp follows shadow dp[i] unless the digit is blanked.
- With ACTIVE_LOW=1, a_to_g, dp and an are the bitwise inverse of the active-high form.

## Timing
- All outputs are registered. Output at cycle n reflects idx and shadow at cycle n-1, giving 1-cycle latency.
- Reset (clr=1 at an edge) values:
  - prescaler 0, idx 0, scan_idx 0, all shadows 0
  - an, a_to_g and dp all inactive: all-ones when ACTIVE_LOW=1, all-zeros otherwise
- First edge after clr deasserts: an selects digit 0 showing "0".
- Digit period is exactly REFRESH_DIV cycles. Full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Exactly one anode is active in every non-reset cycle. There is no anode overlap at digit switch, because anode and segments change on the same edge.
- Simultaneous events:
  - clr with load: clr wins, shadow becomes 0.
  - load at terminal count: both take effect, and the next digit shows the new data.
- clr mid-frame aborts the scan immediately. The next frame restarts at digit 0 with a full REFRESH_DIV hold.

## Structure
- seg7_pkg holds:
  - 16-entry active-high glyph constant table
  - SEG_BLANK constant
  - clog2 function for idx width
- Sub-module seg7_glyph: combinational nibble→7-bit active-high lookup from the package table. Polarity inversion stays in the top block.
- Top block contains the prescaler, idx counter, shadow registers, zero-run detector (reduction over upper nibbles) and output registers.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless stated.
- Reset: hold clr 3 cycles → an=1111, a_to_g=1111111, dp=1. First cycle after release → an=1110, a_to_g=0000001.
- Scan: load value=16'h1A3F, digit_en=1111, dp_in=0100, blank_lz=0 → digits cycle 0..3 every 4 cycles:
  - 0: F = 0111000
  - 1: 3 = 0000110
  - 2: A = 0001000, dp=0
  - 3: 1 = 1001111
  - an sequence 1110, 1101, 1011, 0111, then wraps.
- Leading zeros: load value=16'h0050, blank_lz=1 →
  - digits 3 and 2 blank: a_to_g=1111111, anodes still stepping
  - digit 1 shows 5 = 0100100, digit 0 shows 0
  - value=0 → only digit 0 shows "0"
- Load timing: load 16'h0000 then 16'hFFFF mid-digit → change visible exactly one cycle after the load edge; prescaler phase unchanged. clr asserted with load → shadow 0.
- Enables/polarity:
  - digit_en=0101 → digits 1 and 3 dark, anodes still step.
  - Rerun with ACTIVE_LOW=0 → all outputs bitwise inverted, reset values all zero.
- Frame length with NUM_DIGITS=8, REFRESH_DIV=3: an returns to digit 0 every 24 cycles. scan_idx matches the active anode each cycle. Exactly one anode active every cycle.
